// File: rtl/ipb_pkg.sv
// ----------------------------------------------------------------------------
// ipb_pkg
// Shared definitions for the instruction prefetch buffer:
//   ipb_state_e          - controller state encoding (IDLE / FETCH / FLUSH)
//   ipb_entry_t          - one 64-bit buffer entry {instruction, pc}
//   IPB_DEPTH_DEFAULT    - default buffer depth / outstanding-request limit
//   IPB_RESET_PC_DEFAULT - default first fetch address after reset
// ----------------------------------------------------------------------------
package ipb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } ipb_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ipb_entry_t;

  localparam int unsigned IPB_DEPTH_DEFAULT    = 4;
  localparam logic [31:0] IPB_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ipb_fifo.sv
// ----------------------------------------------------------------------------
// ipb_fifo
// Synchronous DEPTH x 64-bit FIFO holding fetched {instruction, pc} pairs.
// Head entry is presented combinationally; push and pop in the same cycle
// both take effect. Clear empties the FIFO and wins over push/pop.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (control state only)
//   i_push      - write i_data at the tail
//   i_pop       - drop the head entry (ignored when empty)
//   i_clear     - discard all entries
//   i_data      - entry to write
//   o_data      - head entry (undefined when o_count == 0)
//   o_count     - number of valid entries
// ----------------------------------------------------------------------------
module ipb_fifo
  import ipb_pkg::*;
#(
  parameter int DEPTH = IPB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  ipb_entry_t               i_data,
  output ipb_entry_t               o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  ipb_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW + 1)'(w_do_push) - (AW + 1)'(w_do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// inst_prefetch_buffer
// Fetches sequential instruction words ahead of the core into a small FIFO,
// keeping at most DEPTH words buffered-or-in-flight. A redirect flushes the
// buffer and drains responses still in flight before fetching the new path.
// Parameters: DEPTH (power of 2, 2..16), RESET_PC (first fetch address).
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   redirect, redirect_pc    - core PC change; flushes buffer
//   inst_out, inst_pc        - head instruction and its address (0 when empty)
//   inst_valid, inst_ready   - head valid / core pops head
//   mem_req, mem_addr        - memory read request and word address
//   mem_gnt                  - request accepted
//   mem_rvalid, mem_rdata    - in-order read response
//   perf_starve_cnt          - only with IPB_PERF_EN defined: saturating count
//                              of cycles the core waited on an empty buffer
// ----------------------------------------------------------------------------
module inst_prefetch_buffer
  import ipb_pkg::*;
#(
  parameter int          DEPTH    = IPB_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = IPB_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef IPB_PERF_EN
  ,
  output logic [31:0] perf_starve_cnt
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT_X = (CW + 1)'(DEPTH);

  ipb_state_e    r_state;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_stale;

  logic [CW-1:0] w_fifo_count;
  ipb_entry_t    w_head;
  ipb_entry_t    w_push_data;
  logic          w_mem_req;
  logic          w_grant;
  logic          w_rsp;
  logic          w_redirect;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_stale_next;

  assign w_mem_req  = (r_state == FETCH) &&
                      (({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < LIMIT_X);
  assign w_grant    = w_mem_req && mem_gnt;
  assign w_redirect = redirect && (r_state != IDLE);

  // A response only counts when something is actually in flight; strays are dropped.
  assign w_rsp = mem_rvalid &&
                 (((r_state == FETCH) && (r_outstanding != '0)) ||
                  ((r_state == FLUSH) && (r_stale != '0)));

  assign w_push = w_rsp && (r_state == FETCH) && !w_redirect;
  assign w_pop  = inst_valid && inst_ready && !w_redirect;

  // Requests since the last redirect are consecutive words, so the oldest
  // in-flight request (the one answering now) is fetch_pc - 4*outstanding.
  assign w_push_data.inst = mem_rdata;
  assign w_push_data.pc   = r_fetch_pc - (32'(r_outstanding) << 2);

  // In-flight count left behind by a redirect: FETCH tracks it as outstanding,
  // FLUSH as stale (no grants can occur in FLUSH).
  assign w_stale_next = ((r_state == FLUSH) ? r_stale : r_outstanding) +
                        CW'(w_grant) - CW'(w_rsp);

  ipb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else if (w_redirect) begin
      r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
      r_outstanding <= '0;
      r_stale       <= w_stale_next;
      r_state       <= (w_stale_next != '0) ? FLUSH : FETCH;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
          r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
        end
        FLUSH: begin
          if (r_stale == '0) begin
            r_state <= FETCH;
          end else if (w_rsp) begin
            r_stale <= r_stale - CW'(1);
            if (r_stale == CW'(1)) r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign inst_valid = (w_fifo_count != '0);
  assign inst_out   = inst_valid ? w_head.inst : 32'h0;
  assign inst_pc    = inst_valid ? w_head.pc   : 32'h0;
  assign mem_req    = w_mem_req;
  assign mem_addr   = r_fetch_pc;

`ifdef IPB_PERF_EN
  logic [31:0] r_perf_starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_starve_cnt <= '0;
    end else if (inst_ready && !inst_valid && (r_state != IDLE) &&
                 (r_perf_starve_cnt != '1)) begin
      r_perf_starve_cnt <= r_perf_starve_cnt + 32'd1;
    end
  end

  assign perf_starve_cnt = r_perf_starve_cnt;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_inst_prefetch_buffer
// Bench for inst_prefetch_buffer (DEPTH=4, RESET_PC=0). A behavioural memory
// answers granted requests in order after one cycle; delivered instructions
// are checked against a queue of expected PCs restarted on every redirect.
// ----------------------------------------------------------------------------
module tb_inst_prefetch_buffer;

  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef IPB_PERF_EN
  logic [31:0] perf_starve_cnt;
`endif

  inst_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
`ifdef IPB_PERF_EN
    ,
    .perf_starve_cnt (perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int grants = 0;
  logic gnt_en, rsp_en, spur;
  logic last_rv, last_gnt;
  logic [31:0] pend [$];
  logic [31:0] exp_q [$];
  logic [31:0] glog [$];

  typedef struct {
    logic        rdy;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic logic [31:0] model(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One clock: drive memory at the falling edge, score any pop, then return
  // just after the rising edge where outputs are stable for sampling.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    if (spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
    end else if (rsp_en && pend.size() != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = model(pend[0]);
      void'(pend.pop_front());
    end
    mem_gnt  = gnt_en;
    last_rv  = mem_rvalid;
    last_gnt = mem_req && mem_gnt;
    if (mem_req && mem_gnt) begin
      pend.push_back(mem_addr);
      glog.push_back(mem_addr);
      grants++;
    end
    if (redirect) begin
      sb_restart({redirect_pc[31:2], 2'b00});
      glog.delete();
    end else if (inst_valid && inst_ready) begin
      consumed++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h expected none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst_out, model(e));
        exp_q.push_back(e + 32'd32);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic g, input logic r);
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = rdy;
    gnt_en = g;
    rsp_en = r;
    spur = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    pend.delete();
    glog.delete();
    grants = 0;
    sb_restart(RPC);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RPC);
`ifdef IPB_PERF_EN
    chk("rst_perf", perf_starve_cnt, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic wait_consumes(input string nm, input int n, input int budget);
    int start;
    start = consumed;
    for (int i = 0; i < budget && (consumed - start) < n; i++) tick();
    chk(nm, 32'((consumed - start) >= n), 32'd1);
  endtask

  initial begin
    vec_t vt [8];
    int gaps;
    int c0;
    int flush_cyc;
    int vld_flush;
    logic [31:0] wexp [3];

    // start-up with the core stalled: 4 grants fill the buffer, head stays at 0
    vt[0] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
    vt[6] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd0};

    do_reset(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      inst_ready = vt[i].rdy;
      gnt_en     = vt[i].gnt;
      chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vt[i].exp_req));
      chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_vld", i), 32'(inst_valid), 32'(vt[i].exp_vld));
      chk($sformatf("vec%0d_pc", i), inst_pc, vt[i].exp_pc);
      chk($sformatf("vec%0d_out", i), inst_out,
          vt[i].exp_vld ? model(vt[i].exp_pc) : 32'h0);
      tick();
    end
    chk("fill_grants", 32'(grants), 32'd4);

    // release the core: one instruction per cycle, no bubbles
    inst_ready = 1'b1;
    gaps = 0;
    c0 = consumed;
    for (int i = 0; i < 16; i++) begin
      if (!inst_valid) gaps++;
      tick();
    end
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_count", 32'(consumed - c0), 32'd16);

    // three requests in flight, then redirect to 0x100
    do_reset(1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("flush_pre_grants", 32'(grants), 32'd3);
    gnt_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    inst_ready = 1'b1;
    flush_cyc = 0;
    vld_flush = 0;
    while (!mem_req && flush_cyc < 20) begin
      if (inst_valid) vld_flush++;
      flush_cyc++;
      tick();
    end
    chk("flush_len_ok", 32'(flush_cyc >= 3 && flush_cyc < 20), 32'd1);
    chk("flush_vld", 32'(vld_flush), 32'd0);
    chk("flush_resume_addr", mem_addr, 32'h100);
    wait_consumes("flush_deliver", 3, 20);

    // redirect in a cycle that also has a grant and a response
    repeat (6) tick();
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    tick();
    redirect = 1'b0;
    chk("coinc_rv", 32'(last_rv), 32'd1);
    chk("coinc_gnt", 32'(last_gnt), 32'd1);
    chk("coinc_vld_after", 32'(inst_valid), 32'd0);
    chk("coinc_flush_req", 32'(mem_req), 32'd0);
    tick();
    chk("coinc_resume_req", 32'(mem_req), 32'd1);
    chk("coinc_resume_addr", mem_addr, 32'h2000);
    wait_consumes("coinc_deliver", 3, 20);

    // address wrap at the top of memory
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    wait_consumes("wrap_deliver", 4, 40);
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    chk("wrap_glog_size", 32'(glog.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("wrap_addr%0d", i), (glog.size() > i) ? glog[i] : 32'hDEAD_BEEF, wexp[i]);

    // stray response with nothing in flight is ignored (reset mid-stream first)
    do_reset(1'b0, 1'b0, 1'b1);
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("stray_vld", 32'(inst_valid), 32'd0);
    chk("stray_req", 32'(mem_req), 32'd1);

`ifdef IPB_PERF_EN
    chk("perf_idle", perf_starve_cnt, 32'd0);
    inst_ready = 1'b1;
    repeat (5) tick();
    inst_ready = 1'b0;
    tick();
    chk("perf_starve5", perf_starve_cnt, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
